vga_capture: RTL

//  Receive end of the VGA link. Samples an 8-bit RGB pixel bus plus negative-polarity h_sync/v_sync

---
 rtl/vga_capture.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// VGA receive end: syncs h/v/rgb, recovers pixel phase and position, checks timing, emits locked pixels.
// Optional VGA_CAPTURE_STATS_EN keeps the measured line/frame totals on meas_h_total/meas_v_total.
module vga_capture #(
  parameter int CLK_PER_PXL = 4,
  parameter int H_VIS       = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_VIS       = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  vgaRed,
  input  logic [2:0]  vgaGreen,
  input  logic [1:0]  vgaBlue,
  output logic        pxl_valid,
  output logic [7:0]  pxl_data,
  output logic [9:0]  pxl_col,
  output logic [9:0]  pxl_row,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [10:0] meas_h_total,
  output logic [9:0]  meas_v_total
);
  localparam int PW    = $clog2(CLK_PER_PXL);
  localparam int GW    = $clog2(LOCK_FRAMES + 1);
  localparam int H_OFF = H_SYNC + H_BP;
  localparam int V_OFF = V_SYNC + V_BP;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t          state;
  logic [2:0]      h_sr;
  logic [2:0]      v_sr;
  logic [7:0]      rgb_s1;
  logic [7:0]      rgb_s2;
  logic [PW-1:0]   phase;
  logic [9:0]      h_pos;
  logic [9:0]      v_pos;
  logic [GW-1:0]   good_cnt;
  logic            h_armed;
  logic            err_at_vs;
  logic            h_fall;
  logic            v_fall;
  logic            h_chk;
  logic            v_chk;
  logic            line_err;
  logic            frame_err;
  logic            err_now;
  logic            sample;
  logic            h_vis;
  logic            v_vis;
  logic            go_search;

  // stage 2 is the synchronised value, stage 3 its previous copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sr   <= 3'b111;
      v_sr   <= 3'b111;
      rgb_s1 <= '0;
      rgb_s2 <= '0;
    end else begin
      h_sr   <= {h_sr[1:0], h_sync};
      v_sr   <= {v_sr[1:0], v_sync};
      rgb_s1 <= {vgaBlue, vgaGreen, vgaRed};
      rgb_s2 <= rgb_s1;
    end
  end

  assign h_fall = h_sr[2] & ~h_sr[1];
  assign v_fall = v_sr[2] & ~v_sr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      h_pos <= '0;
      v_pos <= '0;
    end else begin
      if (h_fall) begin
        phase <= '0;
        h_pos <= '0;
      end else if (phase == PW'(CLK_PER_PXL - 1)) begin
        phase <= '0;
        if (h_pos != 10'h3ff)
          h_pos <= h_pos + 10'd1;
      end else begin
        phase <= phase + PW'(1);
      end
      if (v_fall)
        v_pos <= '0;
      else if (h_fall && v_pos != 10'h3ff)
        v_pos <= v_pos + 10'd1;
    end
  end

  assign h_chk     = h_fall & h_armed;
  assign v_chk     = v_fall & (state != SEARCH);
  assign line_err  = h_chk & ((h_pos == 10'h3ff) ||
                     ({1'b0, h_pos} + 11'd1 != 11'(H_TOTAL)));
  assign frame_err = v_chk & ((v_pos == 10'h3ff) ||
                     ({1'b0, v_pos} + 11'd1 != 11'(V_TOTAL)));
  assign err_now   = line_err | frame_err;
  assign go_search = timing_err & (state != SEARCH) & ~err_at_vs;

  // an error found on a v_sync fall already marks a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
      err_at_vs  <= 1'b0;
      h_armed    <= 1'b0;
    end else begin
      timing_err <= err_now;
      err_at_vs  <= v_fall;
      if (go_search)
        h_armed <= 1'b0;
      else if (h_fall)
        h_armed <= 1'b1;
      unique case (state)
        SEARCH: begin
          if (v_fall) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (timing_err) begin
            state    <= err_at_vs ? MEASURE : SEARCH;
            good_cnt <= '0;
          end else if (v_fall && !err_now) begin
            if (good_cnt == GW'(LOCK_FRAMES - 1)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
        end
        LOCKED: begin
          if (timing_err) begin
            state    <= err_at_vs ? MEASURE : SEARCH;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign sample = (phase == PW'(CLK_PER_PXL / 2));
  assign h_vis  = (h_pos >= 10'(H_OFF)) && (h_pos < 10'(H_OFF + H_VIS));
  assign v_vis  = (v_pos >= 10'(V_OFF)) && (v_pos < 10'(V_OFF + V_VIS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxl_valid   <= 1'b0;
      pxl_data    <= '0;
      pxl_col     <= '0;
      pxl_row     <= '0;
      frame_start <= 1'b0;
    end else begin
      pxl_valid   <= sample & h_vis & v_vis & (state == LOCKED);
      frame_start <= 1'b0;
      if (sample && h_vis && v_vis && state == LOCKED) begin
        pxl_data    <= rgb_s2;
        pxl_col     <= h_pos - 10'(H_OFF);
        pxl_row     <= v_pos - 10'(V_OFF);
        frame_start <= (h_pos == 10'(H_OFF)) && (v_pos == 10'(V_OFF));
      end
    end
  end

`ifdef VGA_CAPTURE_STATS_EN
  logic [10:0] h_meas;
  logic [9:0]  v_meas;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_meas <= '0;
      v_meas <= '0;
    end else begin
      if (h_chk)
        h_meas <= {1'b0, h_pos} + 11'd1;
      if (v_fall)
        v_meas <= v_pos + 10'd1;
    end
  end

  assign meas_h_total = h_meas;
  assign meas_v_total = v_meas;
`else
  assign meas_h_total = '0;
  assign meas_v_total = '0;
`endif

endmodule
